lcd_controller: RTL and testbench
=================================

LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 SHALL have parameter T_SETUP, default 2, meaning clock cycles RS/DATA are stable before EN rises.
REQ-002 SHALL have parameter T_EN, default 12, meaning clock cycles EN is held high.
REQ-003 SHALL have parameter T_HOLD, default 2, meaning clock cycles RS/DATA are held after EN falls.
REQ-004 SHALL have parameter T_EXEC, default 2000, meaning post-pulse wait cycles for a normal command or data write.
REQ-005 SHALL have parameter T_CLEAR, default 82000, meaning post-pulse wait cycles for clear-display or return-home.
REQ-006 SHALL have port i_clk, input, 1, the single clock for all state.
REQ-007 SHALL have port i_reset, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port i_lcd_we, input, 1, one-cycle write strobe from the CPU store path to the LCD register.
REQ-009 SHALL have port i_lcd_word, input, 32, CPU word: [31]=ON, [30]=clear-overflow, [9]=RS, [7:0]=DATA, other bits ignored.
REQ-010 SHALL have port o_lcd_data, output, 8, LCD data bus.
REQ-011 SHALL have port o_lcd_rs, output, 1, register select (0=command, 1=data).
REQ-012 SHALL have port o_lcd_rw, output, 1, read/write select, tied 0 (write only).
REQ-013 SHALL have port o_lcd_en, output, 1, LCD enable strobe.
REQ-014 SHALL have port o_lcd_on, output, 1, LCD power/backlight enable.
REQ-015 SHALL have port o_busy, output, 1, a transaction is in progress.
REQ-016 SHALL have port o_status, output, 32, CPU-readable status: [31]=ON, [1]=overflow, [0]=busy, others 0.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD, WAIT with a single down-counter sized $clog2(max(T_CLEAR,T_EXEC)+1) bits.
REQ-018 SHALL latch o_lcd_on from i_lcd_word[31] on every i_lcd_we, in any state, effective the next cycle.
REQ-019 SHALL, on i_lcd_we with i_lcd_word[30]=1, clear overflow and start no transaction, in any state.
REQ-020 SHALL, on i_lcd_we with [30]=0 in IDLE, register RS/DATA and enter SETUP the next cycle; o_busy=1 from that cycle.
REQ-021 SHALL hold SETUP for T_SETUP cycles with o_lcd_en=0, then PULSE for T_EN cycles with o_lcd_en=1, then HOLD for T_HOLD cycles with o_lcd_en=0.
REQ-022 SHALL keep o_lcd_data/o_lcd_rs constant from SETUP entry through WAIT exit.
REQ-023 SHALL select WAIT length T_CLEAR when RS=0 and DATA is 8'h01 or 8'h02, otherwise T_EXEC.
REQ-024 SHALL return to IDLE after WAIT expires; o_busy=0 in the first IDLE cycle.
REQ-025 SHALL, on i_lcd_we with [30]=0 while not IDLE (including the last WAIT cycle), drop the write and set sticky overflow.
REQ-026 SHALL give overflow clear priority over set when both occur in one cycle (cannot occur from a single strobe; the rule applies regardless).
REQ-027 SHALL make o_status purely combinational from registered state, with no added latency.
REQ-028 SHALL treat any zero-valued timing parameter as one cycle.

Reset
REQ-029 SHALL, while i_reset=0, asynchronously force FSM=IDLE, counter=0, overflow=0, o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0, o_busy=0, o_status=0.
REQ-030 SHALL abort any in-flight transaction on reset, including one mid-PULSE, with EN dropping immediately.
REQ-031 SHALL accept a write on the first clock edge after i_reset rises.

Verification (T_SETUP=2, T_EN=3, T_HOLD=2, T_EXEC=5, T_CLEAR=20)
REQ-032 SHALL cover data write: we, word=32'h8000_0241 -> on=1, rs=1, data=8'h41; en high cycles 3-5 after accept; busy for 12 cycles; status=32'h8000_0001 while busy.
REQ-033 SHALL cover clear: we, word=32'h8000_0001 -> rs=0, data=8'h01; busy for 27 cycles.
REQ-034 SHALL cover overflow: second write 4 cycles after the first -> dropped, data unchanged, status[1]=1; then word=32'h4000_0000 -> status[1]=0 and no en pulse.
REQ-035 SHALL cover the boundary: a write in the last WAIT cycle is dropped with overflow; a write in the first IDLE cycle is accepted.
REQ-036 SHALL cover reset during PULSE: assert i_reset=0 -> en, busy, on, and status are 0 immediately; write after release completes normally.

Source files
------------

// File: rtl/lcd_controller.sv
// HD44780-style LCD write controller driven by a CPU-mapped register.
// A write strobe either clears the overflow flag or launches one bus
// transaction: setup, enable pulse, hold, then an execution wait whose
// length depends on whether the command is a slow clear/home command.
// Writes arriving while a transaction is still running are dropped and
// recorded in a sticky overflow flag.

module lcd_controller #(
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lcd_we,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic [31:0] o_status
);

  // A zero timing parameter still has to occupy one cycle, so every phase
  // length is clamped to at least one.
  localparam int SETUP_LEN = (T_SETUP < 1) ? 1 : T_SETUP;
  localparam int EN_LEN    = (T_EN    < 1) ? 1 : T_EN;
  localparam int HOLD_LEN  = (T_HOLD  < 1) ? 1 : T_HOLD;
  localparam int EXEC_LEN  = (T_EXEC  < 1) ? 1 : T_EXEC;
  localparam int CLEAR_LEN = (T_CLEAR < 1) ? 1 : T_CLEAR;

  // The counter is sized by the longest wait. The short bus phases normally
  // fit easily; the extra max terms only matter for odd parameter sets where
  // a bus phase outlasts both waits, so their load values never truncate.
  localparam int WAIT_MAX  = (CLEAR_LEN > EXEC_LEN) ? CLEAR_LEN : EXEC_LEN;
  localparam int BUS_MAX_A = (SETUP_LEN > EN_LEN) ? SETUP_LEN : EN_LEN;
  localparam int BUS_MAX   = (BUS_MAX_A > HOLD_LEN) ? BUS_MAX_A : HOLD_LEN;
  localparam int CNT_MAX   = (WAIT_MAX > BUS_MAX) ? WAIT_MAX : BUS_MAX;
  localparam int CW        = $clog2(CNT_MAX + 1);

  // The counter is loaded with length-1 on phase entry and the phase ends
  // in the cycle where it reads zero, giving exactly 'length' cycles.
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_LEN - 1);
  localparam logic [CW-1:0] EN_LOAD    = CW'(EN_LEN - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_LEN - 1);
  localparam logic [CW-1:0] EXEC_LOAD  = CW'(EXEC_LEN - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_LEN - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] PULSE = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          overflow;

  logic write_req;
  logic ovf_clear;
  logic ovf_set;
  logic accept;
  logic cnt_zero;
  logic slow_cmd;
  logic word_unused;

  // Only ON, clear-overflow, RS and DATA carry meaning in the CPU word.
  assign word_unused = ^{i_lcd_word[29:10], i_lcd_word[8]};

  assign write_req = i_lcd_we & ~i_lcd_word[30];
  assign ovf_clear = i_lcd_we &  i_lcd_word[30];
  assign accept    = write_req & (state == IDLE);
  assign ovf_set   = write_req & (state != IDLE);
  assign cnt_zero  = (cnt == '0);

  // Clear-display (0x01) and return-home (0x02) need the long wait.
  assign slow_cmd  = ~o_lcd_rs & ((o_lcd_data == 8'h01) | (o_lcd_data == 8'h02));

  // Next-state and counter sequencing through setup, pulse, hold and wait.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_nxt = PULSE;
          cnt_nxt   = EN_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_nxt = WAIT;
          cnt_nxt   = slow_cmd ? CLEAR_LOAD : EXEC_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and the registered EN/busy outputs; reset aborts any
  // transaction and drops EN immediately.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      o_lcd_en <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      o_lcd_en <= (state_nxt == PULSE);
      o_busy   <= (state_nxt != IDLE);
    end
  end

  // RS/DATA are captured only when a transaction is accepted, so they stay
  // stable for the whole transaction even if further writes are dropped.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_lcd_data <= 8'h00;
      o_lcd_rs   <= 1'b0;
    end else if (accept) begin
      o_lcd_data <= i_lcd_word[7:0];
      o_lcd_rs   <= i_lcd_word[9];
    end
  end

  // Power bit follows every CPU write regardless of transaction state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_lcd_on <= 1'b0;
    end else if (i_lcd_we) begin
      o_lcd_on <= i_lcd_word[31];
    end
  end

  // Sticky overflow flag; a clear request wins over a simultaneous set.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      overflow <= 1'b0;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end
  end

  assign o_lcd_rw = 1'b0;
  assign o_status = {o_lcd_on, 29'd0, overflow, o_busy};

endmodule

// File: tb/tb_lcd_controller.sv
// Self-checking bench for lcd_controller: a cycle table for a data write,
// hand sequences for clear, overflow, the WAIT/IDLE boundary and reset
// mid-pulse, then random traffic against a timeline-based reference model.

module tb_lcd_controller;

  localparam int T_SETUP = 2;
  localparam int T_EN    = 3;
  localparam int T_HOLD  = 2;
  localparam int T_EXEC  = 5;
  localparam int T_CLEAR = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] word = 32'h0;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;
  logic        busy;
  logic [31:0] status;

  int tests = 0;
  int fails = 0;

  // Reference model: a transaction is a time window starting at the edge
  // that accepted it; all outputs follow from the elapsed cycle count.
  int         cyc = 0;
  int         acc = -1;
  int         m_total = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_rs = 1'b0;
  logic       m_on = 1'b0;
  logic       m_ovf = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] word;
    logic        en;
    logic        busy;
    logic        rs;
    logic [7:0]  data;
    logic [31:0] status;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  lcd_controller #(
    .T_SETUP(T_SETUP),
    .T_EN(T_EN),
    .T_HOLD(T_HOLD),
    .T_EXEC(T_EXEC),
    .T_CLEAR(T_CLEAR)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_lcd_we(we),
    .i_lcd_word(word),
    .o_lcd_data(lcd_data),
    .o_lcd_rs(lcd_rs),
    .o_lcd_rw(lcd_rw),
    .o_lcd_en(lcd_en),
    .o_lcd_on(lcd_on),
    .o_busy(busy),
    .o_status(status)
  );

  function automatic bit m_busy();
    return (acc >= 0) && ((cyc - acc) < m_total);
  endfunction

  function automatic bit m_en();
    return (acc >= 0) && ((cyc - acc) >= T_SETUP) && ((cyc - acc) < T_SETUP + T_EN);
  endfunction

  function automatic logic [31:0] m_status();
    return {m_on, 29'd0, m_ovf, m_busy()};
  endfunction

  function automatic vec_t mk(input logic w, input logic [31:0] wd, input logic e,
                              input logic b, input logic [31:0] st);
    vec_t v;
    v.we = w; v.word = wd; v.en = e; v.busy = b; v.rs = 1'b1; v.data = 8'h41; v.status = st;
    return v;
  endfunction

  task automatic model_reset();
    cyc = 0; acc = -1; m_total = 0;
    m_data = 8'h00; m_rs = 1'b0; m_on = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of CPU input, advance the model across the edge, and
  // leave the bench 1 time unit after the edge for sampling.
  task automatic apply_stimulus(input logic w, input logic [31:0] wd);
    bit was_busy;
    we = w;
    word = wd;
    was_busy = m_busy();
    @(posedge clk);
    cyc++;
    if (w) begin
      m_on = wd[31];
      if (wd[30]) begin
        m_ovf = 1'b0;
      end else if (was_busy) begin
        m_ovf = 1'b1;
      end else begin
        acc = cyc;
        m_rs = wd[9];
        m_data = wd[7:0];
        m_total = T_SETUP + T_EN + T_HOLD +
                  ((!wd[9] && (wd[7:0] == 8'h01 || wd[7:0] == 8'h02)) ? T_CLEAR : T_EXEC);
      end
    end
    #1;
    we = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check_output({tag, ".data"}, {24'd0, lcd_data}, {24'd0, m_data});
    check_output({tag, ".rs"}, {31'd0, lcd_rs}, {31'd0, m_rs});
    check_output({tag, ".rw"}, {31'd0, lcd_rw}, 32'd0);
    check_output({tag, ".en"}, {31'd0, lcd_en}, {31'd0, m_en()});
    check_output({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy()});
    check_output({tag, ".status"}, status, m_status());
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      apply_stimulus(1'b0, 32'h0);
      check_model(tag);
    end
    check_output({tag, ".drain_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int en_cnt;

    vecs[0]  = mk(1'b1, 32'h8000_0241, 1'b0, 1'b1, 32'h8000_0001);
    vecs[1]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0001);
    vecs[2]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0001);
    vecs[3]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0001);
    vecs[4]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0001);
    vecs[5]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0001);
    vecs[6]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0001);
    vecs[7]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0001);
    vecs[8]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0001);
    vecs[9]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0001);
    vecs[10] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0001);
    vecs[11] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0001);
    vecs[12] = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0000);

    // Reset state
    model_reset();
    #1;
    check_output("reset.status", status, 32'h0);
    check_output("reset.outs", {20'd0, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on},
                 32'h0);
    check_output("reset.busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Data write, cycle by cycle from the table
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].word);
      check_output($sformatf("tbl[%0d].en", i), {31'd0, lcd_en}, {31'd0, vecs[i].en});
      check_output($sformatf("tbl[%0d].busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      check_output($sformatf("tbl[%0d].rs", i), {31'd0, lcd_rs}, {31'd0, vecs[i].rs});
      check_output($sformatf("tbl[%0d].data", i), {24'd0, lcd_data}, {24'd0, vecs[i].data});
      check_output($sformatf("tbl[%0d].status", i), status, vecs[i].status);
    end

    // Clear display: long wait
    apply_stimulus(1'b1, 32'h8000_0001);
    check_output("clear.rs", {31'd0, lcd_rs}, 32'd0);
    check_output("clear.data", {24'd0, lcd_data}, 32'h01);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      n++;
      apply_stimulus(1'b0, 32'h0);
      check_model("clear");
    end
    check_output("clear.busy_cycles", n, 27);

    // Overflow: second write dropped, then cleared without a pulse
    apply_stimulus(1'b1, 32'h8000_0241);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 32'h0);
    apply_stimulus(1'b1, 32'h8000_0155);
    check_output("ovf.data_kept", {24'd0, lcd_data}, 32'h41);
    check_output("ovf.flag_set", {31'd0, status[1]}, 32'd1);
    check_model("ovf.after_drop");
    apply_stimulus(1'b1, 32'h4000_0000);
    check_output("ovf.flag_clear", {31'd0, status[1]}, 32'd0);
    check_output("ovf.status", status, 32'h0000_0001);
    drain("ovf");
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 32'h0);
      if (lcd_en) en_cnt++;
    end
    check_output("ovf.no_en_pulse", en_cnt, 0);

    // Boundary: write in last WAIT cycle dropped, in first IDLE accepted
    apply_stimulus(1'b1, 32'h8000_0241);
    for (int i = 0; i < 11; i++) apply_stimulus(1'b0, 32'h0);
    check_output("bnd.last_wait_busy", {31'd0, busy}, 32'd1);
    apply_stimulus(1'b1, 32'h8000_0263);
    check_output("bnd.idle_after", {31'd0, busy}, 32'd0);
    check_output("bnd.dropped_data", {24'd0, lcd_data}, 32'h41);
    check_output("bnd.ovf", {31'd0, status[1]}, 32'd1);
    apply_stimulus(1'b1, 32'h8000_0277);
    check_output("bnd.accept_busy", {31'd0, busy}, 32'd1);
    check_output("bnd.accept_data", {24'd0, lcd_data}, 32'h77);
    check_model("bnd");
    drain("bnd");

    // Reset mid-pulse, then a clean write after release
    apply_stimulus(1'b1, 32'h8000_0241);
    apply_stimulus(1'b0, 32'h0);
    apply_stimulus(1'b0, 32'h0);
    check_output("rstp.en_before", {31'd0, lcd_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("rstp.en", {31'd0, lcd_en}, 32'd0);
    check_output("rstp.busy", {31'd0, busy}, 32'd0);
    check_output("rstp.on", {31'd0, lcd_on}, 32'd0);
    check_output("rstp.status", status, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1'b1, 32'h8000_0232);
    check_output("rstp.accept", {31'd0, busy}, 32'd1);
    check_model("rstp.first");
    en_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (lcd_en) en_cnt++;
      if (!busy) break;
      apply_stimulus(1'b0, 32'h0);
      check_model("rstp.run");
    end
    check_output("rstp.en_cycles", en_cnt, T_EN);
    check_output("rstp.done", {31'd0, busy}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        w;
      logic [31:0] wd;
      w = ($urandom_range(0, 5) == 0);
      wd = $urandom;
      wd[30] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        wd[9] = 1'b0;
        wd[7:0] = 8'($urandom_range(1, 2));
      end
      apply_stimulus(w, wd);
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
